// File: rtl/quickq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | quickq_pkg : key width, depth and FSM encoding for queue_ctrl     |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
package quickq_pkg;

  localparam int KEY_W = 32;
  localparam int DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENQ_SCAN = 2'd1,
    ST_DEQ_SCAN = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/queue_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | queue_ctrl : sorted-array priority queue controller (min at 0)    |
// | Revision   : 1.0                                                 |
// +------------------------------------------------------------------+
module queue_ctrl #(
  parameter int KEY_W = quickq_pkg::KEY_W,
  parameter int DEPTH = quickq_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [KEY_W-1:0] enq_key,
  input  logic             deq_req,
  output logic             deq_ready,
  output logic             deq_valid,
  output logic [KEY_W-1:0] deq_key,
  output logic             full,
  output logic             empty,
  output logic [31:0]      count,
  input  logic [31:0]      array_cnt_out,
  output logic             cnt_rst,
  output logic             array_cnt_ld,
  output logic             array_cnt_clr,
  output logic             array_cnt_decr,
  output logic             array_cnt_inc,
  output logic [31:0]      last_index,
  output logic [31:0]      rd_addr,
  input  logic [KEY_W-1:0] rd_data,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [KEY_W-1:0] wr_data
);

  import quickq_pkg::*;

  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  state_e           state_q, state_d;
  logic [31:0]      count_q, count_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] deq_key_q, deq_key_d;
  logic             deq_valid_q, deq_valid_d;

  logic             deq_fire;
  logic             enq_fire;
  logic             enq_stop;
  logic             deq_stop;
  logic [32:0]      p_plus1;

  logic             cmd_rst, cmd_ld, cmd_clr, cmd_decr, cmd_inc;
  logic             wr_en_c;
  logic [31:0]      rd_addr_c, wr_addr_c;
  logic [KEY_W-1:0] wr_data_c;

  assign full       = (count_q == DEPTH_U);
  assign empty      = (count_q == '0);
  assign count      = count_q;
  assign last_index = count_q;
  assign deq_valid  = deq_valid_q;
  assign deq_key    = deq_key_q;

  // Dequeue has priority: enq_ready drops whenever a dequeue is being accepted.
  assign deq_ready = (state_q == ST_IDLE) && !empty && !flush;
  assign enq_ready = (state_q == ST_IDLE) && !full && !flush && !(deq_req && deq_ready);
  assign deq_fire  = deq_req && deq_ready;
  assign enq_fire  = enq_valid && enq_ready;

  // Unsigned <= places a new key behind any equal keys already stored.
  assign enq_stop = (array_cnt_out == '0) || (rd_data <= key_q);
  assign p_plus1  = {1'b0, array_cnt_out} + 33'd1;
  assign deq_stop = (p_plus1 >= {1'b0, count_q});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      key_q       <= '0;
      deq_key_q   <= '0;
      deq_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      key_q       <= key_d;
      deq_key_q   <= deq_key_d;
      deq_valid_q <= deq_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (deq_fire) begin
            state_d = ST_DEQ_SCAN;
          end else if (enq_fire) begin
            state_d = ST_ENQ_SCAN;
          end
        end
        ST_ENQ_SCAN: begin
          if (enq_stop) begin
            state_d = ST_IDLE;
          end
        end
        ST_DEQ_SCAN: begin
          if (deq_stop) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    count_d     = count_q;
    key_d       = key_q;
    deq_key_d   = deq_key_q;
    deq_valid_d = 1'b0;
    cmd_rst     = 1'b0;
    cmd_ld      = 1'b0;
    cmd_clr     = 1'b0;
    cmd_decr    = 1'b0;
    cmd_inc     = 1'b0;
    rd_addr_c   = '0;
    wr_en_c     = 1'b0;
    wr_addr_c   = '0;
    wr_data_c   = '0;
    if (flush) begin
      cmd_rst = 1'b1;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (deq_fire) begin
            deq_key_d   = rd_data;
            deq_valid_d = 1'b1;
            cmd_clr     = 1'b1;
          end else if (enq_fire) begin
            key_d  = enq_key;
            cmd_ld = 1'b1;
          end
        end
        ST_ENQ_SCAN: begin
          // Walk down from the tail, shifting larger keys up by one slot.
          rd_addr_c = array_cnt_out - 32'd1;
          wr_en_c   = 1'b1;
          wr_addr_c = array_cnt_out;
          if (enq_stop) begin
            wr_data_c = key_q;
            if (count_q != DEPTH_U) begin
              count_d = count_q + 32'd1;
            end
          end else begin
            wr_data_c = rd_data;
            cmd_decr  = 1'b1;
          end
        end
        ST_DEQ_SCAN: begin
          if (deq_stop) begin
            if (count_q != '0) begin
              count_d = count_q - 32'd1;
            end
          end else begin
            rd_addr_c = array_cnt_out + 32'd1;
            wr_en_c   = 1'b1;
            wr_addr_c = array_cnt_out;
            wr_data_c = rd_data;
            cmd_inc   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // rst is active-low: commands and writes are forced off while it is held.
  assign cnt_rst        = cmd_rst  & rst;
  assign array_cnt_ld   = cmd_ld   & rst;
  assign array_cnt_clr  = cmd_clr  & rst;
  assign array_cnt_decr = cmd_decr & rst;
  assign array_cnt_inc  = cmd_inc  & rst;
  assign wr_en          = wr_en_c  & rst;
  assign rd_addr        = rd_addr_c;
  assign wr_addr        = wr_addr_c;
  assign wr_data        = wr_data_c;

endmodule
`default_nettype wire

// File: tb/tb_queue_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_queue_ctrl : directed bench with pointer and storage models    |
// | Revision      : 1.0                                              |
// +------------------------------------------------------------------+
module tb_queue_ctrl;

  localparam int KW = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          enq_valid = 1'b0;
  logic [KW-1:0] enq_key = '0;
  logic          deq_req = 1'b0;
  logic          enq_ready, deq_ready, deq_valid, full, empty;
  logic [KW-1:0] deq_key;
  logic [31:0]   count, array_cnt_out, last_index, rd_addr, wr_addr;
  logic          cnt_rst, array_cnt_ld, array_cnt_clr, array_cnt_decr, array_cnt_inc;
  logic [KW-1:0] rd_data, wr_data;
  logic          wr_en;

  logic [31:0]   ptr;
  logic [KW-1:0] mem [DP];
  int            n_checks = 0;
  int            n_pass = 0;
  int            n_wr = 0;
  int            n_cnt_rst = 0;
  logic [31:0]   last_wr_addr = '0;
  logic          multi_cmd = 1'b0;

  always #5 clk = ~clk;

  queue_ctrl #(.KEY_W(KW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_key(enq_key),
    .deq_req(deq_req), .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_key(deq_key),
    .full(full), .empty(empty), .count(count),
    .array_cnt_out(array_cnt_out), .cnt_rst(cnt_rst), .array_cnt_ld(array_cnt_ld),
    .array_cnt_clr(array_cnt_clr), .array_cnt_decr(array_cnt_decr), .array_cnt_inc(array_cnt_inc),
    .last_index(last_index), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                             ptr <= '0;
    else if (cnt_rst || array_cnt_clr)    ptr <= '0;
    else if (array_cnt_ld)                ptr <= last_index;
    else if (array_cnt_decr)              ptr <= ptr - 32'd1;
    else if (array_cnt_inc)               ptr <= ptr + 32'd1;
  end
  assign array_cnt_out = ptr;

  always @(posedge clk) begin
    if (wr_en) begin
      if (wr_addr < 32'(DP)) mem[wr_addr[1:0]] <= wr_data;
      n_wr         <= n_wr + 1;
      last_wr_addr <= wr_addr;
    end
    if (cnt_rst) n_cnt_rst <= n_cnt_rst + 1;
    if ($countones({cnt_rst, array_cnt_ld, array_cnt_clr, array_cnt_decr, array_cnt_inc}) > 1)
      multi_cmd <= 1'b1;
  end
  assign rd_data = (rd_addr < 32'(DP)) ? mem[rd_addr[1:0]] : '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic enqueue(input logic [KW-1:0] k, input int exp_lat, input string tag);
    int guard;
    int lat;
    logic [31:0] c0;
    guard = 0;
    @(negedge clk);
    while (!enq_ready && guard < 50) begin @(negedge clk); guard++; end
    check({tag, "_rdy"}, 32'(enq_ready), 32'd1);
    c0 = count;
    enq_valid = 1'b1;
    enq_key   = k;
    @(posedge clk); #1;
    enq_valid = 1'b0;
    lat = 0;
    while (count == c0 && lat < 50) begin @(posedge clk); #1; lat++; end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic dequeue(input logic [KW-1:0] exp_key, input int exp_lat, input string tag);
    int guard;
    int lat;
    logic [31:0] c0;
    guard = 0;
    @(negedge clk);
    while (!deq_ready && guard < 50) begin @(negedge clk); guard++; end
    check({tag, "_rdy"}, 32'(deq_ready), 32'd1);
    c0 = count;
    deq_req = 1'b1;
    @(posedge clk); #1;
    deq_req = 1'b0;
    check({tag, "_valid"}, 32'(deq_valid), 32'd1);
    check({tag, "_key"}, 32'(deq_key), 32'(exp_key));
    lat = 0;
    while (count == c0 && lat < 50) begin
      @(posedge clk); #1; lat++;
      if (lat == 1) check({tag, "_pulse"}, 32'(deq_valid), 32'd0);
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    logic [KW-1:0] exp_a [4];
    int guard;
    int wr_before;

    // Reset values while rst is held low
    #12;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", count, 32'd0);
    check("rst_deq_valid", 32'(deq_valid), 32'd0);
    check("rst_deq_key", 32'(deq_key), 32'd0);
    check("rst_enq_ready", 32'(enq_ready), 32'd1);
    check("rst_deq_ready", 32'(deq_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Fill to DEPTH in unsorted order
    enqueue(8'd5, 1, "enq5");
    enqueue(8'd3, 2, "enq3");
    enqueue(8'd9, 1, "enq9");
    enqueue(8'd1, 4, "enq1");
    exp_a = '{8'd1, 8'd3, 8'd5, 8'd9};
    for (int i = 0; i < 4; i++) check($sformatf("fill_mem%0d", i), 32'(mem[i]), 32'(exp_a[i]));
    @(negedge clk);
    check("fill_count", count, 32'd4);
    check("fill_full", 32'(full), 32'd1);
    check("fill_enq_ready", 32'(enq_ready), 32'd0);

    // Drain in ascending order
    dequeue(8'd1, 4, "deq1");
    dequeue(8'd3, 3, "deq3");
    dequeue(8'd5, 2, "deq5");
    dequeue(8'd9, 1, "deq9");
    @(negedge clk);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_deq_ready", 32'(deq_ready), 32'd0);

    // Tie insert: new 7 lands at index 2 with a single write
    enqueue(8'd2, 1, "enq2");
    enqueue(8'd7, 1, "enq7a");
    wr_before = n_wr;
    enqueue(8'd7, 1, "enq7b");
    check("tie_writes", 32'(n_wr - wr_before), 32'd1);
    check("tie_wr_addr", last_wr_addr, 32'd2);
    exp_a = '{8'd2, 8'd7, 8'd7, 8'd0};
    for (int i = 0; i < 3; i++) check($sformatf("tie_mem%0d", i), 32'(mem[i]), 32'(exp_a[i]));
    check("tie_count", count, 32'd3);
    dequeue(8'd2, 3, "deq2");
    dequeue(8'd7, 2, "deq7a");
    dequeue(8'd7, 1, "deq7b");

    // Simultaneous enqueue and dequeue: dequeue wins
    enqueue(8'd4, 1, "enq4");
    deq_req   = 1'b1;
    enq_valid = 1'b1;
    enq_key   = 8'd6;
    @(negedge clk);
    check("both_enq_ready", 32'(enq_ready), 32'd0);
    check("both_deq_ready", 32'(deq_ready), 32'd1);
    @(posedge clk); #1;
    deq_req = 1'b0;
    check("both_deq_valid", 32'(deq_valid), 32'd1);
    check("both_deq_key", 32'(deq_key), 32'd4);
    guard = 0;
    @(negedge clk);
    while (!enq_ready && guard < 50) begin @(negedge clk); guard++; end
    check("both_enq_later", 32'(enq_ready), 32'd1);
    @(posedge clk); #1;
    enq_valid = 1'b0;
    guard = 0;
    while (count != 32'd1 && guard < 50) begin @(posedge clk); #1; guard++; end
    check("both_count", count, 32'd1);
    check("both_mem0", 32'(mem[0]), 32'd6);
    dequeue(8'd6, 1, "deq6");

    // Flush while scanning key 0 into [1,2,3]
    enqueue(8'd1, 1, "enqf1");
    enqueue(8'd2, 1, "enqf2");
    enqueue(8'd3, 1, "enqf3");
    @(negedge clk);
    enq_valid = 1'b1;
    enq_key   = 8'd0;
    @(posedge clk); #1;
    enq_valid = 1'b0;
    flush     = 1'b1;
    wr_before = n_wr;
    @(negedge clk);
    check("flush_cnt_rst", 32'(cnt_rst), 32'd1);
    check("flush_wr_en", 32'(wr_en), 32'd0);
    check("flush_decr", 32'(array_cnt_decr), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_count", count, 32'd0);
    check("flush_empty", 32'(empty), 32'd1);
    check("flush_no_write", 32'(n_wr - wr_before), 32'd0);
    @(negedge clk);
    check("flush_idle", 32'(enq_ready), 32'd1);
    check("flush_cnt_rst_off", 32'(cnt_rst), 32'd0);

    // Asynchronous reset in the middle of a dequeue scan
    enqueue(8'd8, 1, "enqr8");
    enqueue(8'd9, 1, "enqr9");
    @(negedge clk);
    deq_req = 1'b1;
    @(posedge clk); #1;
    deq_req = 1'b0;
    check("scan_wr_en", 32'(wr_en), 32'd1);
    check("scan_inc", 32'(array_cnt_inc), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_deq_valid", 32'(deq_valid), 32'd0);
    check("arst_deq_key", 32'(deq_key), 32'd0);
    check("arst_count", count, 32'd0);
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_wr_en", 32'(wr_en), 32'd0);
    check("arst_inc", 32'(array_cnt_inc), 32'd0);
    check("arst_enq_ready", 32'(enq_ready), 32'd1);
    check("arst_deq_ready", 32'(deq_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_count", count, 32'd0);

    check("one_cmd_per_cycle", 32'(multi_cmd), 32'd0);
    check("cnt_rst_pulses", 32'(n_cnt_rst), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
